// File: rtl/spram_fifo_pkg.sv
// Shared sizing helpers for the single-port-RAM stream FIFO.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package spram_fifo_pkg;

  // Prefetch queue holds two RAM rows so one row can be consumed while the next is fetched.
  localparam int RBUF_DEPTH = 4;

  // Write-pairing stage collects one RAM row worth of entries.
  localparam int WBUF_SLOTS = 2;

  // Two entries share each RAM row.
  function automatic int rows_of(input int depth);
    return depth / 2;
  endfunction

endpackage

// File: rtl/spram_row.sv
// Single-port synchronous RAM, one access per cycle, write-first.
// Latency: read data valid the cycle after the access (registered address).
// Backpressure: none; the caller arbitrates the single port.
module spram_row
  import spram_fifo_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_d;

  // Address is held between accesses so rdata stays stable.
  always_comb begin
    addr_d = addr_q;
    if (en) addr_d = addr;
  end

  // Registered address: reading through it after a write returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  // Storage array is never reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/spram_fifo_wide.sv
// Valid/ready FIFO on a single-port RAM packed two entries per row; optional peak tracker under SPRAM_FIFO_WATERMARK_EN.
// Latency: push into an empty FIFO is visible on m_valid two cycles later; one push and one pop per cycle sustained.
// Backpressure: s_ready = count < FIFO_DEPTH; m_valid holds the head until m_ready.
module spram_fifo_wide
  import spram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
`ifdef SPRAM_FIFO_WATERMARK_EN
  ,
  input  logic                  wm_clear,
  output logic [ADDR_WIDTH:0]   max_count
`endif
);

  localparam int ROWS  = rows_of(FIFO_DEPTH);
  localparam int RW    = ADDR_WIDTH - 1;
  localparam int RCW   = RW + 1;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int RB_AW = $clog2(RBUF_DEPTH);
  localparam int RB_CW = RB_AW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] wbuf_q [WBUF_SLOTS];
  logic [DATA_WIDTH-1:0] wbuf_d [WBUF_SLOTS];
  logic [1:0]            wcnt_q, wcnt_d;
  logic [RW-1:0]         wrow_q, wrow_d, rrow_q, rrow_d;
  logic [RCW-1:0]        ram_rows_q, ram_rows_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] rbuf_q [RBUF_DEPTH];
  logic [DATA_WIDTH-1:0] rbuf_d [RBUF_DEPTH];
  logic [RB_AW-1:0]      rhead_q, rhead_d;
  logic [RB_CW-1:0]      rcnt_q, rcnt_d;

  logic                    push, pop, do_drain, do_write, do_read;
  logic [RB_CW-1:0]        rcnt_after_pop;
  logic [RB_CW:0]          rdemand;
  logic [RB_AW-1:0]        rtail, rtail1;
  logic                    ram_en, ram_we;
  logic [RW-1:0]           ram_addr;
  logic [2*DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign s_ready = (count_q < CW'(FIFO_DEPTH));
  assign m_valid = (rcnt_q != '0);
  assign m_data  = rbuf_q[rhead_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);

  // Port arbitration (drain > write > read) and next state for every stage.
  always_comb begin
    push = s_valid && s_ready;
    pop  = m_valid && m_ready;
    rcnt_after_pop = rcnt_q - RB_CW'(pop);
    // Rows already fetched but not yet landed still claim rbuf space.
    rdemand = {1'b0, rcnt_after_pop} + (inflight_q ? (RB_CW+1)'(2) : '0);

    // Bypass the RAM only while it and the read pipe are empty, keeping entries in age order.
    do_drain = (ram_rows_q == '0) && !inflight_q && (wcnt_q != 2'd0) &&
               (rcnt_after_pop < RB_CW'(RBUF_DEPTH));
    do_write = !do_drain && (wcnt_q == 2'd2);
    do_read  = !do_drain && !do_write && (ram_rows_q != '0) &&
               (rdemand <= (RB_CW+1)'(RBUF_DEPTH - 2));

    count_d    = count_q + CW'(push) - CW'(pop);
    wrow_d     = wrow_q + RW'(do_write);
    rrow_d     = rrow_q + RW'(do_read);
    ram_rows_d = ram_rows_q + RCW'(do_write) - RCW'(do_read);
    inflight_d = do_read;

    ram_en    = do_write || do_read;
    ram_we    = do_write;
    ram_addr  = do_write ? wrow_q : rrow_q;
    ram_wdata = {wbuf_q[1], wbuf_q[0]};

    // Pairing stage: retire slot0 or the whole pair, then land the new push behind the survivors.
    wbuf_d = wbuf_q;
    wcnt_d = wcnt_q;
    if (do_drain) begin
      wbuf_d[0] = wbuf_q[1];
      wcnt_d    = wcnt_q - 2'd1;
    end else if (do_write) begin
      wcnt_d = 2'd0;
    end
    if (push) begin
      wbuf_d[wcnt_d[0]] = s_data;
      wcnt_d            = wcnt_d + 2'd1;
    end

    // Prefetch queue: the tail is unaffected by a pop, so both sources write at head+count.
    rtail   = rhead_q + rcnt_q[RB_AW-1:0];
    rtail1  = rtail + RB_AW'(1);
    rbuf_d  = rbuf_q;
    if (do_drain) rbuf_d[rtail] = wbuf_q[0];
    if (inflight_q) begin
      rbuf_d[rtail]  = ram_rdata[DATA_WIDTH-1:0];
      rbuf_d[rtail1] = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end
    rhead_d = rhead_q + RB_AW'(pop);
    rcnt_d  = rcnt_after_pop + RB_CW'(do_drain) + (inflight_q ? RB_CW'(2) : '0);
  end

  // State registers; reset discards all held entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wbuf_q     <= '{default: '0};
      wcnt_q     <= '0;
      wrow_q     <= '0;
      rrow_q     <= '0;
      ram_rows_q <= '0;
      inflight_q <= 1'b0;
      rbuf_q     <= '{default: '0};
      rhead_q    <= '0;
      rcnt_q     <= '0;
    end else begin
      count_q    <= count_d;
      wbuf_q     <= wbuf_d;
      wcnt_q     <= wcnt_d;
      wrow_q     <= wrow_d;
      rrow_q     <= rrow_d;
      ram_rows_q <= ram_rows_d;
      inflight_q <= inflight_d;
      rbuf_q     <= rbuf_d;
      rhead_q    <= rhead_d;
      rcnt_q     <= rcnt_d;
    end
  end

  spram_row #(
    .ROWS  (ROWS),
    .WIDTH (2*DATA_WIDTH),
    .AW    (RW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef SPRAM_FIFO_WATERMARK_EN
  logic [CW-1:0] max_count_q, max_count_d;

  // Peak occupancy tracker; clear reloads it from the present count.
  always_comb begin
    max_count_d = max_count_q;
    if (wm_clear)                 max_count_d = count_q;
    else if (count_q > max_count_q) max_count_d = count_q;
  end

  // Peak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_count_q <= '0;
    else        max_count_q <= max_count_d;
  end

  assign max_count = max_count_q;
`endif

endmodule
